gnn_aggr_layer: RTL and testbench

GNN_AGGR_LAYER -- requirements
Module: gnn_aggr_layer

---
 rtl/gnn_aggr_layer.sv | 146 ++++++++++++++
 tb/tb_gnn_aggr_layer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_aggr_layer.sv
// One-layer graph aggregation: each node sums its neighbours' features (AGGR),
// then projects the aggregate through a weight matrix (MAC), with optional ReLU.
module gnn_aggr_layer #(
    parameter int N_NODES = 4,
    parameter int N_FEAT  = 4,
    parameter int N_OUT   = 2,
    parameter int XW      = 5,
    parameter int WW      = 5,
    localparam int AW = XW + $clog2(N_NODES),
    localparam int OW = AW + WW + $clog2(N_FEAT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_NODES*N_FEAT*XW-1:0]  x_flat,
    input  logic [N_NODES*N_NODES-1:0]    adj,
    input  logic [N_FEAT*N_OUT*WW-1:0]    w_flat,
    input  logic                          relu_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NODES*N_OUT*OW-1:0]   y_flat,
    output logic                          busy
);

    localparam int NW = $clog2(N_NODES);
    localparam int FW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [NW-1:0] NODE_LAST = NW'(N_NODES - 1);
    localparam logic [FW-1:0] FEAT_LAST = FW'(N_FEAT - 1);

    typedef enum logic [1:0] {IDLE, AGGR, MAC, DONE} state_t;

    state_t state, state_next;

    logic [N_NODES*N_FEAT*XW-1:0] x_r;
    logic [N_NODES*N_NODES-1:0]   adj_r;
    logic [N_FEAT*N_OUT*WW-1:0]   w_r;
    logic                         relu_r;

    logic [NW-1:0] n_idx;
    logic [NW-1:0] j_idx;
    logic [FW-1:0] f_idx;

    logic signed [AW-1:0] acc      [N_FEAT];
    logic signed [AW-1:0] acc_next [N_FEAT];
    logic signed [OW-1:0] sum      [N_OUT];
    logic signed [OW-1:0] sum_next [N_OUT];

    logic        [XW-1:0] x_val;
    logic        [WW-1:0] w_val;
    logic signed [OW-1:0] a_ext;
    logic signed [OW-1:0] w_ext;

    assign in_ready  = (state == IDLE);
    assign busy      = (state == AGGR) || (state == MAC);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = AGGR;
            AGGR: if (j_idx == NODE_LAST) state_next = MAC;
            MAC:  if (f_idx == FEAT_LAST) state_next = (n_idx == NODE_LAST) ? DONE : AGGR;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of both accumulator banks; only the one matching the state is committed.
    always_comb begin
        x_val = '0;
        w_val = '0;
        a_ext = '0;
        w_ext = '0;
        for (int f = 0; f < N_FEAT; f++) begin
            x_val       = x_r[(int'(j_idx)*N_FEAT + f)*XW +: XW];
            acc_next[f] = adj_r[int'(n_idx)*N_NODES + int'(j_idx)]
                        ? acc[f] + {{(AW-XW){x_val[XW-1]}}, x_val}
                        : acc[f];
        end
        a_ext = {{(OW-AW){acc[f_idx][AW-1]}}, acc[f_idx]};
        for (int o = 0; o < N_OUT; o++) begin
            w_val       = w_r[(int'(f_idx)*N_OUT + o)*WW +: WW];
            w_ext       = {{(OW-WW){w_val[WW-1]}}, w_val};
            sum_next[o] = sum[o] + a_ext * w_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_r    <= '0;
            adj_r  <= '0;
            w_r    <= '0;
            relu_r <= 1'b0;
            n_idx  <= '0;
            j_idx  <= '0;
            f_idx  <= '0;
            y_flat <= '0;
            for (int f = 0; f < N_FEAT; f++) acc[f] <= '0;
            for (int o = 0; o < N_OUT; o++)  sum[o] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r    <= x_flat;
                        adj_r  <= adj;
                        w_r    <= w_flat;
                        relu_r <= relu_en;
                        n_idx  <= '0;
                        j_idx  <= '0;
                        f_idx  <= '0;
                        for (int f = 0; f < N_FEAT; f++) acc[f] <= '0;
                        for (int o = 0; o < N_OUT; o++)  sum[o] <= '0;
                    end
                end
                AGGR: begin
                    for (int f = 0; f < N_FEAT; f++) acc[f] <= acc_next[f];
                    j_idx <= (j_idx == NODE_LAST) ? '0 : j_idx + 1'b1;
                    f_idx <= '0;
                end
                MAC: begin
                    if (f_idx == FEAT_LAST) begin
                        // Final product folds straight into the node's output slot.
                        for (int o = 0; o < N_OUT; o++)
                            y_flat[(int'(n_idx)*N_OUT + o)*OW +: OW] <=
                                (relu_r && sum_next[o][OW-1]) ? '0 : sum_next[o];
                        for (int f = 0; f < N_FEAT; f++) acc[f] <= '0;
                        for (int o = 0; o < N_OUT; o++)  sum[o] <= '0;
                        f_idx <= '0;
                        if (n_idx != NODE_LAST) n_idx <= n_idx + 1'b1;
                    end else begin
                        for (int o = 0; o < N_OUT; o++) sum[o] <= sum_next[o];
                        f_idx <= f_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gnn_aggr_layer.sv
// Scoreboard bench for gnn_aggr_layer at default parameters: a reference model
// computes each job's results at drive time and they are checked on out_valid.
module tb_gnn_aggr_layer;

    localparam int NN = 4;
    localparam int NF = 4;
    localparam int NO = 2;
    localparam int XW = 5;
    localparam int WW = 5;
    localparam int OW = 14;
    localparam int XF = NN*NF*XW;
    localparam int AF = NN*NN;
    localparam int WF = NF*NO*WW;
    localparam int YF = NN*NO*OW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [XF-1:0] x_flat;
    logic [AF-1:0] adj;
    logic [WF-1:0] w_flat;
    logic          relu_en;
    logic          out_valid;
    logic          out_ready;
    logic [YF-1:0] y_flat;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    logic [YF-1:0] sb_q[$];

    gnn_aggr_layer #(
        .N_NODES(NN), .N_FEAT(NF), .N_OUT(NO), .XW(XW), .WW(WW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_flat(x_flat), .adj(adj), .w_flat(w_flat), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .y_flat(y_flat), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [YF-1:0] model(input logic [XF-1:0] x, input logic [AF-1:0] a,
                                            input logic [WF-1:0] w, input logic relu);
        logic [YF-1:0] y;
        int agg[NF];
        int r;
        y = '0;
        for (int n = 0; n < NN; n++) begin
            for (int f = 0; f < NF; f++) begin
                agg[f] = 0;
                for (int j = 0; j < NN; j++)
                    if (a[n*NN+j]) agg[f] += int'($signed(x[(j*NF+f)*XW +: XW]));
            end
            for (int o = 0; o < NO; o++) begin
                r = 0;
                for (int f = 0; f < NF; f++) r += agg[f] * int'($signed(w[(f*NO+o)*WW +: WW]));
                if (relu && r < 0) r = 0;
                y[(n*NO+o)*OW +: OW] = r[OW-1:0];
            end
        end
        return y;
    endfunction

    function automatic logic [XF-1:0] fill_x(input int v);
        logic [XF-1:0] x;
        for (int i = 0; i < NN*NF; i++) x[i*XW +: XW] = v[XW-1:0];
        return x;
    endfunction

    function automatic logic [WF-1:0] fill_w(input int v);
        logic [WF-1:0] w;
        for (int i = 0; i < NF*NO; i++) w[i*WW +: WW] = v[WW-1:0];
        return w;
    endfunction

    task automatic check_y(input logic [YF-1:0] exp);
        for (int n = 0; n < NN; n++)
            for (int o = 0; o < NO; o++)
                checkOutput($sformatf("y[%0d][%0d]", n, o),
                            y_flat[(n*NO+o)*OW +: OW], exp[(n*NO+o)*OW +: OW]);
    endtask

    // Offer a job, push its expected results, then scramble the inputs after accept.
    task automatic applyStimulus(input logic [XF-1:0] x, input logic [AF-1:0] a,
                                 input logic [WF-1:0] w, input logic relu);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 0, 1);
            return;
        end
        x_flat   = x;
        adj      = a;
        w_flat   = w;
        relu_en  = relu;
        in_valid = 1'b1;
        sb_q.push_back(model(x, a, w, relu));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_flat   = ~x_flat;
        adj      = ~adj;
        w_flat   = ~w_flat;
        relu_en  = ~relu_en;
    endtask

    task automatic collect_result(input int hold);
        int cycles = 0;
        logic [YF-1:0] exp;
        while (cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 1) checkOutput("busy_running", busy, 1);
            if (out_valid) break;
        end
        checkOutput("latency", cycles, 32);
        if (!out_valid) return;
        if (sb_q.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
            return;
        end
        exp = sb_q.pop_front();
        check_y(exp);
        checkOutput("busy_done", busy, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            x_flat   = ~x_flat;
            @(posedge clk);
            #1;
            checkOutput("y_hold", y_flat, exp);
            checkOutput("in_ready_hold", in_ready, 0);
            checkOutput("out_valid_hold", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("in_ready_after", in_ready, 1);
        checkOutput("out_valid_after", out_valid, 0);
        checkOutput("y_retained", y_flat, exp);
    endtask

    initial begin
        logic [XF-1:0] x_seq;
        logic [95:0]   r96;
        logic [63:0]   r64;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_flat    = '0;
        adj       = '0;
        w_flat    = '0;
        relu_en   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_y", y_flat, 0);

        $display("[TB] all-ones job");
        applyStimulus(fill_x(1), '1, fill_w(1), 1'b0);
        collect_result(0);

        $display("[TB] ramp features with partial adjacency");
        for (int j = 0; j < NN; j++)
            for (int f = 0; f < NF; f++) x_seq[(j*NF+f)*XW +: XW] = XW'(j + 1);
        applyStimulus(x_seq, 16'b1110_1101_1011_0111, fill_w(1), 1'b0);
        collect_result(0);

        $display("[TB] extreme values and ReLU");
        applyStimulus(fill_x(-16), '1, fill_w(-16), 1'b0);
        collect_result(0);
        applyStimulus(fill_x(-16), '1, fill_w(15), 1'b0);
        collect_result(0);
        applyStimulus(fill_x(-16), '1, fill_w(15), 1'b1);
        collect_result(0);

        $display("[TB] back-pressure in DONE");
        applyStimulus(fill_x(1), '1, fill_w(1), 1'b0);
        collect_result(10);

        $display("[TB] reset during a job");
        applyStimulus(fill_x(1), '1, fill_w(1), 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_y", y_flat, 0);
        checkOutput("abort_in_ready", in_ready, 1);
        if (sb_q.size() > 0) void'(sb_q.pop_back());
        applyStimulus(fill_x(1), '1, fill_w(1), 1'b0);
        collect_result(0);

        $display("[TB] empty adjacency row");
        applyStimulus(fill_x(1), 16'hF0FF, fill_w(1), 1'b0);
        collect_result(0);

        $display("[TB] random jobs");
        for (int k = 0; k < 4; k++) begin
            r96 = {$urandom(), $urandom(), $urandom()};
            r64 = {$urandom(), $urandom()};
            applyStimulus(r96[XF-1:0], AF'($urandom()), r64[WF-1:0], 1'($urandom_range(0, 1)));
            collect_result(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
